// File: rtl/spi_tx_fifo.sv
// Transmit sample FIFO between the sample source and the SPI shifter.
// Circular buffer of 2^ADDR_W 16-bit words with a registered, one-cycle-latency pop port.
module spi_tx_fifo #(
  parameter int ADDR_W = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [15:0]       data_in,
  input  logic              flag_data_in,
  input  logic              flag_rd_fifo,
  output logic [15:0]       fifo_data,
  output logic              flag_fifo_data,
  output logic [ADDR_W:0]   fifo_count,
  output logic              fifo_empty,
  output logic              fifo_full,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

  logic [15:0]       mem [DEPTH];
  logic [ADDR_W-1:0] wrPtr_q, wrPtr_d;
  logic [ADDR_W-1:0] rdPtr_q, rdPtr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [15:0]       data_q, data_d;
  logic              flag_q, flag_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              wrEn, rdEn;
  logic              isEmpty, isFull;

  assign isEmpty = (count_q == '0);
  assign isFull  = (count_q == FULL_COUNT);

  // A write into a full buffer still lands when a pop frees the slot on the same edge.
  assign wrEn = flag_data_in && (!isFull || flag_rd_fifo);
  assign rdEn = flag_rd_fifo && !isEmpty;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    data_d  = data_q;
    flag_d  = rdEn;
    ovf_d   = ovf_q | (flag_data_in & isFull & ~flag_rd_fifo);
    unf_d   = unf_q | (flag_rd_fifo & isEmpty);

    if (wrEn) wrPtr_d = wrPtr_q + ADDR_W'(1);

    // An empty read is not a fall-through: it returns zero even if a write coincides.
    if (rdEn) begin
      rdPtr_d = rdPtr_q + ADDR_W'(1);
      data_d  = mem[rdPtr_q];
    end else if (flag_rd_fifo) begin
      data_d = '0;
    end

    case ({wrEn, rdEn})
      2'b10:   count_d = count_q + (ADDR_W+1)'(1);
      2'b01:   count_d = count_q - (ADDR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      data_q  <= '0;
      flag_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
      data_q  <= data_d;
      flag_q  <= flag_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage is left uninitialised by reset; only the write itself is blocked.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst && wrEn) mem[wrPtr_q] <= data_in;
  end

  assign fifo_data      = data_q;
  assign flag_fifo_data = flag_q;
  assign fifo_count     = count_q;
  assign fifo_empty     = isEmpty;
  assign fifo_full      = isFull;
  assign overflow       = ovf_q;
  assign underflow      = unf_q;

endmodule

// File: tb/tb_spi_tx_fifo.sv
// Directed self-checking bench for spi_tx_fifo with the default 16-word depth.
module tb_spi_tx_fifo;

  logic        sys_clk;
  logic        sys_rst;
  logic [15:0] data_in;
  logic        flag_data_in;
  logic        flag_rd_fifo;
  logic [15:0] fifo_data;
  logic        flag_fifo_data;
  logic [4:0]  fifo_count;
  logic        fifo_empty;
  logic        fifo_full;
  logic        overflow;
  logic        underflow;

  int passCount;
  int checkCount;

  spi_tx_fifo #(.ADDR_W(4)) dut (
    .sys_clk        (sys_clk),
    .sys_rst        (sys_rst),
    .data_in        (data_in),
    .flag_data_in   (flag_data_in),
    .flag_rd_fifo   (flag_rd_fifo),
    .fifo_data      (fifo_data),
    .flag_fifo_data (flag_fifo_data),
    .fifo_count     (fifo_count),
    .fifo_empty     (fifo_empty),
    .fifo_full      (fifo_full),
    .overflow       (overflow),
    .underflow      (underflow)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // One clock with the given strobes; outputs are sampled 1 time unit after the edge.
  task automatic cycle(input logic wr, input logic [15:0] d, input logic rd);
    flag_data_in = wr;
    data_in      = d;
    flag_rd_fifo = rd;
    @(posedge sys_clk);
    #1;
    flag_data_in = 1'b0;
    flag_rd_fifo = 1'b0;
  endtask

  task automatic doReset();
    sys_rst = 1'b1;
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    flag_data_in = 1'b1;
    flag_rd_fifo = 1'b1;
    data_in = 16'h1111;
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    flag_data_in = 1'b0;
    flag_rd_fifo = 1'b0;
    checkCount++; if (fifo_count !== 5'd0) $display("[TB] FAIL reset_count got %0d expected 0", fifo_count); else passCount++;
    checkCount++; if (fifo_empty !== 1'b1) $display("[TB] FAIL reset_empty got %b expected 1", fifo_empty); else passCount++;
    checkCount++; if (fifo_full !== 1'b0) $display("[TB] FAIL reset_full got %b expected 0", fifo_full); else passCount++;
    checkCount++; if (fifo_data !== 16'h0000) $display("[TB] FAIL reset_data got %h expected 0000", fifo_data); else passCount++;
    checkCount++; if (flag_fifo_data !== 1'b0) $display("[TB] FAIL reset_flag got %b expected 0", flag_fifo_data); else passCount++;
    checkCount++; if ({overflow, underflow} !== 2'b00) $display("[TB] FAIL reset_errors got %b expected 00", {overflow, underflow}); else passCount++;
  endtask

  task automatic test_basic();
    doReset();
    cycle(1'b1, 16'hA5A5, 1'b0);
    cycle(1'b1, 16'h1234, 1'b0);
    checkCount++; if (fifo_count !== 5'd2) $display("[TB] FAIL basic_count2 got %0d expected 2", fifo_count); else passCount++;
    cycle(1'b0, 16'h0000, 1'b1);
    checkCount++; if (fifo_data !== 16'hA5A5) $display("[TB] FAIL basic_read1 got %h expected a5a5", fifo_data); else passCount++;
    checkCount++; if (flag_fifo_data !== 1'b1) $display("[TB] FAIL basic_flag1 got %b expected 1", flag_fifo_data); else passCount++;
    cycle(1'b0, 16'h0000, 1'b1);
    checkCount++; if (fifo_data !== 16'h1234) $display("[TB] FAIL basic_read2 got %h expected 1234", fifo_data); else passCount++;
    checkCount++; if (flag_fifo_data !== 1'b1) $display("[TB] FAIL basic_flag2 got %b expected 1", flag_fifo_data); else passCount++;
    checkCount++; if (fifo_empty !== 1'b1) $display("[TB] FAIL basic_empty got %b expected 1", fifo_empty); else passCount++;
    cycle(1'b0, 16'h0000, 1'b0);
    checkCount++; if (flag_fifo_data !== 1'b0) $display("[TB] FAIL basic_flag_drop got %b expected 0", flag_fifo_data); else passCount++;
    checkCount++; if (fifo_data !== 16'h1234) $display("[TB] FAIL basic_hold got %h expected 1234", fifo_data); else passCount++;
  endtask

  task automatic test_full_overflow();
    doReset();
    for (int i = 0; i < 16; i++) cycle(1'b1, 16'(i), 1'b0);
    checkCount++; if (fifo_full !== 1'b1) $display("[TB] FAIL fill_full got %b expected 1", fifo_full); else passCount++;
    checkCount++; if (overflow !== 1'b0) $display("[TB] FAIL fill_no_ovf got %b expected 0", overflow); else passCount++;
    cycle(1'b1, 16'hFFFF, 1'b0);
    checkCount++; if (overflow !== 1'b1) $display("[TB] FAIL ovf_set got %b expected 1", overflow); else passCount++;
    checkCount++; if (fifo_count !== 5'd16) $display("[TB] FAIL ovf_count got %0d expected 16", fifo_count); else passCount++;
    checkCount++; if (fifo_full !== 1'b1) $display("[TB] FAIL ovf_full got %b expected 1", fifo_full); else passCount++;
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 16'h0000, 1'b1);
      checkCount++; if (fifo_data !== 16'(i)) $display("[TB] FAIL drain_data[%0d] got %h expected %h", i, fifo_data, 16'(i)); else passCount++;
      checkCount++; if (flag_fifo_data !== 1'b1) $display("[TB] FAIL drain_flag[%0d] got %b expected 1", i, flag_fifo_data); else passCount++;
    end
    checkCount++; if (fifo_empty !== 1'b1) $display("[TB] FAIL drain_empty got %b expected 1", fifo_empty); else passCount++;
    checkCount++; if (overflow !== 1'b1) $display("[TB] FAIL ovf_sticky got %b expected 1", overflow); else passCount++;
  endtask

  task automatic test_underflow();
    doReset();
    cycle(1'b1, 16'h5555, 1'b0);
    cycle(1'b0, 16'h0000, 1'b1);
    checkCount++; if (fifo_data !== 16'h5555) $display("[TB] FAIL unf_pre_data got %h expected 5555", fifo_data); else passCount++;
    cycle(1'b0, 16'h0000, 1'b1);
    checkCount++; if (fifo_data !== 16'h0000) $display("[TB] FAIL unf_data got %h expected 0000", fifo_data); else passCount++;
    checkCount++; if (underflow !== 1'b1) $display("[TB] FAIL unf_set got %b expected 1", underflow); else passCount++;
    checkCount++; if (flag_fifo_data !== 1'b0) $display("[TB] FAIL unf_flag got %b expected 0", flag_fifo_data); else passCount++;
    checkCount++; if (fifo_count !== 5'd0) $display("[TB] FAIL unf_count got %0d expected 0", fifo_count); else passCount++;
    cycle(1'b1, 16'h6666, 1'b0);
    cycle(1'b0, 16'h0000, 1'b1);
    checkCount++; if (fifo_data !== 16'h6666) $display("[TB] FAIL unf_rdptr got %h expected 6666", fifo_data); else passCount++;
    checkCount++; if (underflow !== 1'b1) $display("[TB] FAIL unf_sticky got %b expected 1", underflow); else passCount++;
  endtask

  task automatic test_back_to_back();
    doReset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 16'h0100 + 16'(i), 1'b0);
    for (int k = 0; k < 40; k++) begin
      cycle(1'b1, 16'h0103 + 16'(k), 1'b1);
      checkCount++; if (fifo_data !== 16'h0100 + 16'(k)) $display("[TB] FAIL stream_data[%0d] got %h expected %h", k, fifo_data, 16'h0100 + 16'(k)); else passCount++;
      checkCount++; if (fifo_count !== 5'd3) $display("[TB] FAIL stream_count[%0d] got %0d expected 3", k, fifo_count); else passCount++;
    end
  endtask

  task automatic test_simul_edges();
    doReset();
    cycle(1'b1, 16'hBEEF, 1'b1);
    checkCount++; if (underflow !== 1'b1) $display("[TB] FAIL se_empty_unf got %b expected 1", underflow); else passCount++;
    checkCount++; if (fifo_count !== 5'd1) $display("[TB] FAIL se_empty_count got %0d expected 1", fifo_count); else passCount++;
    checkCount++; if (fifo_data !== 16'h0000) $display("[TB] FAIL se_empty_data got %h expected 0000", fifo_data); else passCount++;
    checkCount++; if (flag_fifo_data !== 1'b0) $display("[TB] FAIL se_empty_flag got %b expected 0", flag_fifo_data); else passCount++;
    for (int i = 0; i < 15; i++) cycle(1'b1, 16'h0200 + 16'(i), 1'b0);
    checkCount++; if (fifo_full !== 1'b1) $display("[TB] FAIL se_fill_full got %b expected 1", fifo_full); else passCount++;
    cycle(1'b1, 16'hCAFE, 1'b1);
    checkCount++; if (fifo_count !== 5'd16) $display("[TB] FAIL se_full_count got %0d expected 16", fifo_count); else passCount++;
    checkCount++; if (overflow !== 1'b0) $display("[TB] FAIL se_full_ovf got %b expected 0", overflow); else passCount++;
    checkCount++; if (fifo_data !== 16'hBEEF) $display("[TB] FAIL se_full_data got %h expected beef", fifo_data); else passCount++;
    for (int i = 0; i < 16; i++) begin
      logic [15:0] expVal;
      expVal = (i < 15) ? 16'h0200 + 16'(i) : 16'hCAFE;
      cycle(1'b0, 16'h0000, 1'b1);
      checkCount++; if (fifo_data !== expVal) $display("[TB] FAIL se_drain[%0d] got %h expected %h", i, fifo_data, expVal); else passCount++;
    end
  endtask

  task automatic test_reset_midstream();
    doReset();
    cycle(1'b0, 16'h0000, 1'b1);
    for (int i = 0; i < 6; i++) cycle(1'b1, 16'h0300 + 16'(i), 1'b0);
    cycle(1'b0, 16'h0000, 1'b1);
    checkCount++; if (fifo_count !== 5'd5) $display("[TB] FAIL mid_pre_count got %0d expected 5", fifo_count); else passCount++;
    sys_rst = 1'b1;
    cycle(1'b0, 16'h0000, 1'b1);
    sys_rst = 1'b0;
    checkCount++; if (fifo_count !== 5'd0) $display("[TB] FAIL mid_count got %0d expected 0", fifo_count); else passCount++;
    checkCount++; if (fifo_data !== 16'h0000) $display("[TB] FAIL mid_data got %h expected 0000", fifo_data); else passCount++;
    checkCount++; if (flag_fifo_data !== 1'b0) $display("[TB] FAIL mid_flag got %b expected 0", flag_fifo_data); else passCount++;
    checkCount++; if ({overflow, underflow} !== 2'b00) $display("[TB] FAIL mid_errors got %b expected 00", {overflow, underflow}); else passCount++;
    cycle(1'b1, 16'h7777, 1'b0);
    checkCount++; if (fifo_count !== 5'd1) $display("[TB] FAIL post_rst_write got %0d expected 1", fifo_count); else passCount++;
    cycle(1'b0, 16'h0000, 1'b1);
    checkCount++; if (fifo_data !== 16'h7777) $display("[TB] FAIL post_rst_read got %h expected 7777", fifo_data); else passCount++;
  endtask

  initial begin
    passCount = 0;
    checkCount = 0;
    sys_rst = 1'b1;
    data_in = 16'h0000;
    flag_data_in = 1'b0;
    flag_rd_fifo = 1'b0;
    test_reset();
    test_basic();
    test_full_overflow();
    test_underflow();
    test_back_to_back();
    test_simul_edges();
    test_reset_midstream();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
